// File: rtl/prbs_gen_chk.sv
// ============================================================================
// Module  : prbs_gen_chk
// Brief   : Parallel PRBS word generator with valid/ready handshake, plus a
//           self-synchronising checker with lock tracking and an error counter.
//           Optional error injection when PRBS_ERR_INJECT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_gen_chk #(
    parameter int             W        = 128,
    parameter int             PLEN     = 31,
    parameter int             TAP      = 28,
    parameter int             INV      = 1,
    parameter logic [W-1:0]   SEED     = 128'h0123456789abcdeffedcba9876543210,
    parameter int             LOCK_CNT = 4,
    parameter int             LOSS_CNT = 8,
    parameter int             CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             seed_load,
    input  logic [W-1:0]     seed,
    input  logic             gen_en,
    output logic             gen_valid,
    input  logic             gen_ready,
    output logic [W-1:0]     gen_data,
    input  logic             chk_en,
    input  logic             chk_valid,
    input  logic [W-1:0]     chk_data,
    output logic [1:0]       chk_state,
    output logic             chk_locked,
    output logic             chk_err,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_ERR_INJECT_EN
    ,
    input  logic             inject
`endif
);

    localparam logic INV_BIT = (INV != 0);
    localparam int   MW      = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int   LW      = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // Extend the current word's top PLEN bits by W new sequence bits.
    function automatic logic [W-1:0] prbs_next(input logic [W-1:0] cur);
        logic [PLEN+W-1:0] ext;
        ext = '0;
        ext[PLEN-1:0] = cur[W-1 -: PLEN];
        for (int j = 0; j < W; j++) begin
            ext[PLEN+j] = ext[j] ^ ext[PLEN+j-TAP] ^ INV_BIT;
        end
        return ext[PLEN +: W];
    endfunction

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic [W-1:0] r_gen_data;
    logic         r_gen_valid;
    logic [W-1:0] w_seed_fix;
    logic         w_xfer;

    assign w_seed_fix = (!INV_BIT && (seed == '0)) ? SEED : seed;
    assign gen_valid  = r_gen_valid & ~seed_load;
    assign w_xfer     = gen_valid & gen_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen_data  <= SEED;
            r_gen_valid <= 1'b0;
        end else begin
            r_gen_valid <= gen_en;
            if (clear) begin
                r_gen_data <= SEED;
            end else if (seed_load) begin
                r_gen_data <= w_seed_fix;
            end else if (w_xfer) begin
                r_gen_data <= prbs_next(r_gen_data);
            end
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    logic r_inj;

    // The corruption lives only on the output path; r_gen_data stays clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inj <= 1'b0;
        end else if (inject) begin
            r_inj <= 1'b1;
        end else if (w_xfer) begin
            r_inj <= 1'b0;
        end
    end

    assign gen_data = r_gen_data ^ {{(W-1){1'b0}}, r_inj};
`else
    assign gen_data = r_gen_data;
`endif

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    chk_state_t       r_st, w_st_d;
    logic [W-1:0]     r_prev, w_prev_d;
    logic             r_seeded, w_seeded_d;
    logic [MW-1:0]    r_match, w_match_d;
    logic [LW-1:0]    r_loss, w_loss_d;
    logic             r_err, w_err_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [W-1:0]     w_exp;
    logic             w_hit;

    // In SYNC r_prev is the last received word; in LOCKED it is the
    // internally tracked word, so corrupted input never propagates.
    assign w_exp = prbs_next(r_prev);
    assign w_hit = (chk_data == w_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st     <= ST_IDLE;
            r_prev   <= '0;
            r_seeded <= 1'b0;
            r_match  <= '0;
            r_loss   <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_st     <= w_st_d;
            r_prev   <= w_prev_d;
            r_seeded <= w_seeded_d;
            r_match  <= w_match_d;
            r_loss   <= w_loss_d;
            r_err    <= w_err_d;
            r_cnt    <= w_cnt_d;
        end
    end

    always_comb begin
        w_st_d     = r_st;
        w_prev_d   = r_prev;
        w_seeded_d = r_seeded;
        w_match_d  = r_match;
        w_loss_d   = r_loss;
        w_err_d    = 1'b0;
        w_cnt_d    = r_cnt;

        if (clear) begin
            w_cnt_d = '0;
        end

        if (!chk_en) begin
            w_st_d = ST_IDLE;
        end else if (clear) begin
            w_st_d     = ST_SYNC;
            w_seeded_d = 1'b0;
            w_match_d  = '0;
            w_loss_d   = '0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    w_st_d     = ST_SYNC;
                    w_seeded_d = 1'b0;
                    w_match_d  = '0;
                end
                ST_SYNC: begin
                    if (chk_valid) begin
                        w_prev_d   = chk_data;
                        w_seeded_d = 1'b1;
                        if (!r_seeded || !w_hit) begin
                            w_match_d = '0;
                        end else if (r_match == LOCK_LAST) begin
                            w_st_d    = ST_LOCKED;
                            w_match_d = '0;
                            w_loss_d  = '0;
                        end else begin
                            w_match_d = r_match + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (chk_valid) begin
                        w_prev_d = w_exp;
                        if (w_hit) begin
                            w_loss_d = '0;
                        end else begin
                            w_err_d = 1'b1;
                            if (r_cnt != '1) begin
                                w_cnt_d = r_cnt + 1'b1;
                            end
                            if (r_loss == LOSS_LAST) begin
                                w_st_d     = ST_SYNC;
                                w_seeded_d = 1'b0;
                                w_match_d  = '0;
                                w_loss_d   = '0;
                            end else begin
                                w_loss_d = r_loss + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_st_d = ST_IDLE;
                end
            endcase
        end
    end

    assign chk_state  = r_st;
    assign chk_locked = (r_st == ST_LOCKED);
    assign chk_err    = r_err;
    assign err_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_gen_chk.sv
// ============================================================================
// Module  : tb_prbs_gen_chk
// Brief   : Directed self-checking bench for prbs_gen_chk (default build and
//           PRBS_ERR_INJECT_EN build); second instance covers counter saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_gen_chk;

    localparam int           W    = 128;
    localparam int           PLEN = 31;
    localparam int           TAP  = 28;
    localparam logic [W-1:0] SEED = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] BIT0 = {{(W-1){1'b0}}, 1'b1};

    logic          clk = 1'b0;
    logic          reset, clear, seed_load, gen_en, gen_ready, chk_en, chk_valid, inject;
    logic [W-1:0]  seed, chk_data;
    logic          gen_valid, chk_locked, chk_err;
    logic [W-1:0]  gen_data;
    logic [1:0]    chk_state;
    logic [31:0]   err_cnt;
    logic          gen_valid2, chk_locked2, chk_err2;
    logic [W-1:0]  gen_data2;
    logic [1:0]    chk_state2;
    logic [3:0]    err_cnt2;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] g_exp;

    always #5 clk = ~clk;

    prbs_gen_chk dut (
        .clk(clk), .reset(reset), .clear(clear), .seed_load(seed_load), .seed(seed),
        .gen_en(gen_en), .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_data(gen_data),
        .chk_en(chk_en), .chk_valid(chk_valid), .chk_data(chk_data),
        .chk_state(chk_state), .chk_locked(chk_locked), .chk_err(chk_err), .err_cnt(err_cnt)
`ifdef PRBS_ERR_INJECT_EN
        , .inject(inject)
`endif
    );

    prbs_gen_chk #(.CNT_W(4), .LOSS_CNT(32)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .seed_load(seed_load), .seed(seed),
        .gen_en(gen_en), .gen_valid(gen_valid2), .gen_ready(gen_ready), .gen_data(gen_data2),
        .chk_en(chk_en), .chk_valid(chk_valid), .chk_data(chk_data),
        .chk_state(chk_state2), .chk_locked(chk_locked2), .chk_err(chk_err2), .err_cnt(err_cnt2)
`ifdef PRBS_ERR_INJECT_EN
        , .inject(inject)
`endif
    );

    // Bit-serial recurrence s[n] = s[n-PLEN] ^ s[n-TAP] ^ 1 over two words.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] w);
        logic s [0:2*W-1];
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) s[i] = w[i];
        for (int n = W; n < 2*W; n++) s[n] = s[n-PLEN] ^ s[n-TAP] ^ 1'b1;
        for (int i = 0; i < W; i++) r[i] = s[W+i];
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic loop_step(input logic [W-1:0] mask);
        chk_valid = gen_valid & gen_ready;
        chk_data  = gen_data ^ mask;
        step();
        chk_valid = 1'b0;
    endtask

    task automatic zero_step;
        chk_valid = 1'b1;
        chk_data  = ZERO;
        step();
        chk_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        n_chk++; if (gen_data !== SEED) $display("FAIL rst_gen_data: got %h exp %h", gen_data, SEED); else n_pass++;
        n_chk++; if (gen_valid !== 1'b0) $display("FAIL rst_gen_valid: got %b exp 0", gen_valid); else n_pass++;
        n_chk++; if (chk_state !== 2'd0) $display("FAIL rst_chk_state: got %0d exp 0", chk_state); else n_pass++;
        n_chk++; if (chk_locked !== 1'b0) $display("FAIL rst_chk_locked: got %b exp 0", chk_locked); else n_pass++;
        n_chk++; if (chk_err !== 1'b0) $display("FAIL rst_chk_err: got %b exp 0", chk_err); else n_pass++;
        n_chk++; if (err_cnt !== 32'd0) $display("FAIL rst_err_cnt: got %0d exp 0", err_cnt); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_gen;
        gen_en    = 1'b1;
        gen_ready = 1'b1;
        n_chk++; if (gen_valid !== 1'b0) $display("FAIL gen_valid_pre: got %b exp 0", gen_valid); else n_pass++;
        step();
        n_chk++; if (gen_valid !== 1'b1) $display("FAIL gen_valid_lat: got %b exp 1", gen_valid); else n_pass++;
        n_chk++; if (gen_data !== SEED) $display("FAIL gen_first_word: got %h exp %h", gen_data, SEED); else n_pass++;
        g_exp = SEED;
        for (int k = 1; k <= 3; k++) begin
            step();
            g_exp = ref_next(g_exp);
            n_chk++; if (gen_data !== g_exp) $display("FAIL gen_word%0d: got %h exp %h", k, gen_data, g_exp); else n_pass++;
        end
    endtask

    task automatic test_stall;
        gen_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++; if (gen_data !== g_exp) $display("FAIL stall_data%0d: got %h exp %h", k, gen_data, g_exp); else n_pass++;
            n_chk++; if (gen_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b exp 1", k, gen_valid); else n_pass++;
        end
        gen_ready = 1'b1;
        step();
        g_exp = ref_next(g_exp);
        n_chk++; if (gen_data !== g_exp) $display("FAIL stall_resume: got %h exp %h", gen_data, g_exp); else n_pass++;
    endtask

    task automatic test_lock;
        chk_en = 1'b1;
        step();
        n_chk++; if (chk_state !== 2'd1) $display("FAIL lock_enter_sync: got %0d exp 1", chk_state); else n_pass++;
        for (int k = 0; k < 4; k++) loop_step(ZERO);
        n_chk++; if (chk_state !== 2'd1) $display("FAIL lock_not_yet: got %0d exp 1", chk_state); else n_pass++;
        loop_step(ZERO);
        n_chk++; if (chk_state !== 2'd2) $display("FAIL lock_state: got %0d exp 2", chk_state); else n_pass++;
        n_chk++; if (chk_locked !== 1'b1) $display("FAIL lock_flag: got %b exp 1", chk_locked); else n_pass++;
        n_chk++; if (err_cnt !== 32'd0) $display("FAIL lock_err_cnt: got %0d exp 0", err_cnt); else n_pass++;
    endtask

    task automatic test_single_err;
`ifdef PRBS_ERR_INJECT_EN
        inject = 1'b1;
        loop_step(ZERO);
        inject = 1'b0;
        loop_step(ZERO);
`else
        loop_step(ZERO);
        loop_step(BIT0);
`endif
        n_chk++; if (chk_err !== 1'b1) $display("FAIL err1_pulse: got %b exp 1", chk_err); else n_pass++;
        n_chk++; if (err_cnt !== 32'd1) $display("FAIL err1_cnt: got %0d exp 1", err_cnt); else n_pass++;
        n_chk++; if (chk_state !== 2'd2) $display("FAIL err1_state: got %0d exp 2", chk_state); else n_pass++;
        loop_step(ZERO);
        n_chk++; if (chk_err !== 1'b0) $display("FAIL err1_clean_next: got %b exp 0", chk_err); else n_pass++;
        n_chk++; if (err_cnt !== 32'd1) $display("FAIL err1_cnt_hold: got %0d exp 1", err_cnt); else n_pass++;
        n_chk++; if (chk_locked !== 1'b1) $display("FAIL err1_locked: got %b exp 1", chk_locked); else n_pass++;
    endtask

    task automatic test_loss;
        for (int k = 0; k < 7; k++) zero_step();
        n_chk++; if (chk_state !== 2'd2) $display("FAIL loss_7_state: got %0d exp 2", chk_state); else n_pass++;
        n_chk++; if (err_cnt !== 32'd8) $display("FAIL loss_7_cnt: got %0d exp 8", err_cnt); else n_pass++;
        zero_step();
        n_chk++; if (chk_state !== 2'd1) $display("FAIL loss_8_state: got %0d exp 1", chk_state); else n_pass++;
        n_chk++; if (err_cnt !== 32'd9) $display("FAIL loss_8_cnt: got %0d exp 9", err_cnt); else n_pass++;
        n_chk++; if (chk_err !== 1'b1) $display("FAIL loss_8_pulse: got %b exp 1", chk_err); else n_pass++;
        for (int k = 0; k < 5; k++) loop_step(ZERO);
        n_chk++; if (chk_state !== 2'd2) $display("FAIL relock_state: got %0d exp 2", chk_state); else n_pass++;
        n_chk++; if (err_cnt !== 32'd9) $display("FAIL relock_cnt: got %0d exp 9", err_cnt); else n_pass++;
    endtask

    task automatic test_sat;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 5; k++) loop_step(ZERO);
        n_chk++; if (chk_state2 !== 2'd2) $display("FAIL sat_lock: got %0d exp 2", chk_state2); else n_pass++;
        for (int k = 0; k < 15; k++) zero_step();
        n_chk++; if (err_cnt2 !== 4'd15) $display("FAIL sat_15: got %0d exp 15", err_cnt2); else n_pass++;
        for (int k = 0; k < 5; k++) zero_step();
        n_chk++; if (err_cnt2 !== 4'd15) $display("FAIL sat_20: got %0d exp 15", err_cnt2); else n_pass++;
        n_chk++; if (chk_state2 !== 2'd2) $display("FAIL sat_still_locked: got %0d exp 2", chk_state2); else n_pass++;
        n_chk++; if (err_cnt !== 32'd8) $display("FAIL sat_dut1_cnt: got %0d exp 8", err_cnt); else n_pass++;
        n_chk++; if (chk_state !== 2'd1) $display("FAIL sat_dut1_state: got %0d exp 1", chk_state); else n_pass++;
    endtask

    task automatic test_clear;
        clear     = 1'b1;
        chk_valid = 1'b1;
        chk_data  = ZERO;
        step();
        clear     = 1'b0;
        chk_valid = 1'b0;
        n_chk++; if (err_cnt !== 32'd0) $display("FAIL clr_cnt: got %0d exp 0", err_cnt); else n_pass++;
        n_chk++; if (err_cnt2 !== 4'd0) $display("FAIL clr_cnt2: got %0d exp 0", err_cnt2); else n_pass++;
        n_chk++; if (chk_state2 !== 2'd1) $display("FAIL clr_state2: got %0d exp 1", chk_state2); else n_pass++;
        n_chk++; if (chk_err2 !== 1'b0) $display("FAIL clr_beat_dropped: got %b exp 0", chk_err2); else n_pass++;
        n_chk++; if (gen_data !== SEED) $display("FAIL clr_gen_data: got %h exp %h", gen_data, SEED); else n_pass++;
    endtask

    task automatic test_seed;
        seed      = ZERO;
        seed_load = 1'b1;
        #1;
        n_chk++; if (gen_valid !== 1'b0) $display("FAIL seed_valid_mask: got %b exp 0", gen_valid); else n_pass++;
        step();
        seed_load = 1'b0;
        n_chk++; if (gen_data !== ZERO) $display("FAIL seed_zero_kept: got %h exp %h", gen_data, ZERO); else n_pass++;
        seed      = ONES;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        n_chk++; if (gen_data !== ONES) $display("FAIL seed_ones: got %h exp %h", gen_data, ONES); else n_pass++;
        step();
        n_chk++; if (gen_data !== ONES) $display("FAIL xnor_fixed_point: got %h exp %h", gen_data, ONES); else n_pass++;
        n_chk++; if (gen_valid !== 1'b1) $display("FAIL seed_valid_back: got %b exp 1", gen_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) loop_step(ZERO);
        n_chk++; if (chk_state !== 2'd2) $display("FAIL mid_lock: got %0d exp 2", chk_state); else n_pass++;
        zero_step();
        zero_step();
        n_chk++; if (err_cnt !== 32'd2) $display("FAIL mid_cnt: got %0d exp 2", err_cnt); else n_pass++;
        reset = 1'b1;
        step();
        n_chk++; if (chk_state !== 2'd0) $display("FAIL mid_rst_state: got %0d exp 0", chk_state); else n_pass++;
        n_chk++; if (err_cnt !== 32'd0) $display("FAIL mid_rst_cnt: got %0d exp 0", err_cnt); else n_pass++;
        n_chk++; if (chk_locked !== 1'b0) $display("FAIL mid_rst_locked: got %b exp 0", chk_locked); else n_pass++;
        n_chk++; if (gen_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", gen_valid); else n_pass++;
        n_chk++; if (gen_data !== SEED) $display("FAIL mid_rst_data: got %h exp %h", gen_data, SEED); else n_pass++;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        gen_en    = 1'b0;
        gen_ready = 1'b0;
        chk_en    = 1'b0;
        chk_valid = 1'b0;
        chk_data  = '0;
        inject    = 1'b0;
        g_exp     = '0;
        test_reset();
        test_gen();
        test_stall();
        test_lock();
        test_single_err();
        test_loss();
        test_sat();
        test_clear();
        test_seed();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
